pmp_programmer: RTL and testbench

- CSR-side initiator for the pmp block: accepts one high-level region request (entry, mode, base, size, permissions, lock).
- Encodes the request into RISC-V pmpaddr/pmpcfg values.
- Drives the pmp CSR port (rw_addr/wdata/wr_en/rdata) with a read-modify-write of the packed pmpcfg word.
- Sits between the boot/firmware sequencer and pmp, replacing hand-issued CSR writes.

---
 rtl/pmp_programmer_pkg.sv | 68 ++++++
 rtl/pmp_programmer_if.sv | 24 ++
 rtl/pmp_programmer_addr_encoder.sv | 55 +++++
 rtl/pmp_programmer.sv | 200 ++++++++++++++++++++
 tb/tb_pmp_programmer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmp_programmer_pkg.sv
// Shared types and constants for the PMP region programmer: request modes,
// sequencer states, completion codes, CSR bases and pmpcfg byte-lane helpers.
package pmp_programmer_pkg;

    localparam logic [31:0] PMPCFG_BASE_DEF  = 32'h0000_03A0;
    localparam logic [31:0] PMPADDR_BASE_DEF = 32'h0000_03B0;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } pmp_mode_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_mode_e  a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CFG  = 3'd1,
        ST_RD_PREV = 3'd2,
        ST_EVAL    = 3'd3,
        ST_WR_LO   = 3'd4,
        ST_WR_ADDR = 3'd5,
        ST_WR_CFG  = 3'd6,
        ST_DONE    = 3'd7
    } prog_state_e;

    typedef enum logic [1:0] {
        STAT_OK        = 2'd0,
        STAT_LOCKED    = 2'd1,
        STAT_BAD_ARG   = 2'd2,
        STAT_BAD_RANGE = 2'd3
    } prog_status_e;

    function automatic logic [7:0] cfg_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] res;
        case (lane)
            2'd0:    res = word[7:0];
            2'd1:    res = word[15:8];
            2'd2:    res = word[23:16];
            2'd3:    res = word[31:24];
            default: res = 8'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] cfg_lane_set(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [7:0] val);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = val;
            2'd1:    res[15:8]  = val;
            2'd2:    res[23:16] = val;
            2'd3:    res[31:24] = val;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pmp_programmer_if.sv
// Request/completion handshake between the boot sequencer (master) and
// the PMP programmer (slave).
interface pmp_programmer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_entry;
    logic [1:0]  req_mode;
    logic [31:0] req_base;
    logic [5:0]  req_size_log2;
    logic [2:0]  req_perm;
    logic        req_lock;
    logic        done_valid;
    logic [1:0]  done_status;

    modport master (
        output req_valid, req_entry, req_mode, req_base, req_size_log2, req_perm, req_lock,
        input  req_ready, done_valid, done_status
    );

    modport slave (
        input  req_valid, req_entry, req_mode, req_base, req_size_log2, req_perm, req_lock,
        output req_ready, done_valid, done_status
    );
endinterface

// File: rtl/pmp_programmer_addr_encoder.sv
// Combinational pmpaddr encoder: turns mode/base/size into the pmpaddr value
// (and the TOR lower bound) and flags argument or range violations.
module pmp_addr_encoder
    import pmp_programmer_pkg::*;
(
    input  pmp_mode_e   mode,
    input  logic [31:0] base,
    input  logic [5:0]  size_log2,
    output logic [31:0] addr_val,
    output logic [31:0] lo_val,
    output logic        bad_arg,
    output logic        bad_range
);

    // 35 bits keep base + 2^size exact for every legal size plus a margin
    logic [34:0] span_s;
    logic [34:0] mask_s;
    logic [34:0] top_s;

    // Per-mode encoding and legality checks
    always_comb begin
        span_s    = 35'd1 << size_log2;
        mask_s    = span_s - 35'd1;
        top_s     = {3'b000, base} + span_s;
        lo_val    = base >> 2'd2;
        addr_val  = 32'd0;
        bad_arg   = 1'b0;
        bad_range = 1'b0;
        case (mode)
            MODE_NA4: begin
                addr_val = base >> 2'd2;
                bad_arg  = (size_log2 != 6'd2) || (base[1:0] != 2'b00);
            end
            MODE_NAPOT: begin
                addr_val = (base >> 2'd2) | mask_s[34:3];
                if ((size_log2 < 6'd3) || (size_log2 > 6'd32)) begin
                    bad_arg = 1'b1;
                end else if (({3'b000, base} & mask_s) != 35'd0) begin
                    bad_arg = 1'b1;
                end else begin
                    bad_arg = 1'b0;
                end
            end
            MODE_TOR: begin
                addr_val  = top_s[33:2];
                bad_range = (size_log2 < 6'd2) || (size_log2 > 6'd32) ||
                            (top_s > 35'h1_0000_0000);
            end
            default: begin
                addr_val = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/pmp_programmer.sv
// PMP region programmer: reads the packed pmpcfg word, validates the request,
// then writes pmpaddr (plus TOR lower bound) and the merged pmpcfg word.
module pmp_programmer
    import pmp_programmer_pkg::*;
#(
    parameter logic [31:0] PMPCFG_BASE  = PMPCFG_BASE_DEF,
    parameter logic [31:0] PMPADDR_BASE = PMPADDR_BASE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    pmp_programmer_if.slave  host,
    output logic [1:0]       csr_priv_mode,
    output logic [31:0]      rw_addr,
    output logic [31:0]      wdata,
    output logic             wr_en,
    input  logic [31:0]      rdata
);

    prog_state_e  state_r;
    prog_status_e done_status_r;
    logic         ready_r;
    logic         done_valid_r;
    logic [3:0]   entry_r;
    pmp_mode_e    mode_r;
    logic [31:0]  base_r;
    logic [5:0]   size_r;
    logic [2:0]   perm_r;
    logic         lock_r;
    logic [31:0]  cfg_word_r;
    logic [31:0]  prev_word_r;

    logic [31:0]  addr_val_s;
    logic [31:0]  lo_val_s;
    logic         enc_bad_arg_s;
    logic         enc_bad_range_s;
    logic [7:0]   tgt_byte_s;
    logic [7:0]   below_byte_s;
    logic         locked_s;
    logic         arg_fail_s;
    logic         range_fail_s;
    prog_status_e eval_status_s;
    pmpcfg_t      new_cfg_s;
    logic [31:0]  cfg_merged_s;
    logic [31:0]  cfg_addr_s;
    logic         need_prev_s;

    assign host.req_ready   = ready_r;
    assign host.done_valid  = done_valid_r;
    assign host.done_status = done_status_r;

    pmp_addr_encoder u_encoder (
        .mode      (mode_r),
        .base      (base_r),
        .size_log2 (size_r),
        .addr_val  (addr_val_s),
        .lo_val    (lo_val_s),
        .bad_arg   (enc_bad_arg_s),
        .bad_range (enc_bad_range_s)
    );

    // Lock/argument/range evaluation and the merged pmpcfg word
    always_comb begin
        tgt_byte_s = cfg_lane(cfg_word_r, entry_r[1:0]);
        // entry-1 lives in the previous pmpcfg word when entry sits in lane 0
        if (entry_r[1:0] != 2'd0) begin
            below_byte_s = cfg_lane(cfg_word_r, entry_r[1:0] - 2'd1);
        end else begin
            below_byte_s = prev_word_r[31:24];
        end
        locked_s     = tgt_byte_s[7] ||
                       ((mode_r == MODE_TOR) && (entry_r != 4'd0) && below_byte_s[7]);
        arg_fail_s   = (perm_r[1] && !perm_r[0]) || enc_bad_arg_s;
        range_fail_s = enc_bad_range_s ||
                       ((mode_r == MODE_TOR) && (entry_r == 4'd0) && (base_r != 32'd0));
        if (locked_s) begin
            eval_status_s = STAT_LOCKED;
        end else if (arg_fail_s) begin
            eval_status_s = STAT_BAD_ARG;
        end else if (range_fail_s) begin
            eval_status_s = STAT_BAD_RANGE;
        end else begin
            eval_status_s = STAT_OK;
        end
        new_cfg_s.l    = lock_r;
        new_cfg_s.rsvd = 2'b00;
        new_cfg_s.a    = mode_r;
        new_cfg_s.x    = perm_r[2];
        new_cfg_s.w    = perm_r[1];
        new_cfg_s.r    = perm_r[0];
        cfg_merged_s   = cfg_lane_set(cfg_word_r, entry_r[1:0], new_cfg_s);
        cfg_addr_s     = PMPCFG_BASE + {30'd0, entry_r[3:2]};
        need_prev_s    = (mode_r == MODE_TOR) && (entry_r != 4'd0) && (entry_r[1:0] == 2'd0);
    end

    // Sequencer with registered CSR and handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b1;
            done_valid_r  <= 1'b0;
            done_status_r <= STAT_OK;
            wr_en         <= 1'b0;
            rw_addr       <= 32'd0;
            wdata         <= 32'd0;
            csr_priv_mode <= 2'b01;
            entry_r       <= 4'd0;
            mode_r        <= MODE_OFF;
            base_r        <= 32'd0;
            size_r        <= 6'd0;
            perm_r        <= 3'd0;
            lock_r        <= 1'b0;
            cfg_word_r    <= 32'd0;
            prev_word_r   <= 32'd0;
        end else begin
            wr_en        <= 1'b0;
            done_valid_r <= 1'b0;
            rw_addr      <= 32'd0;
            wdata        <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (host.req_valid && ready_r) begin
                        entry_r       <= host.req_entry;
                        mode_r        <= pmp_mode_e'(host.req_mode);
                        base_r        <= host.req_base;
                        size_r        <= host.req_size_log2;
                        perm_r        <= host.req_perm;
                        lock_r        <= host.req_lock;
                        rw_addr       <= PMPCFG_BASE + {30'd0, host.req_entry[3:2]};
                        ready_r       <= 1'b0;
                        csr_priv_mode <= 2'b00;
                        state_r       <= ST_RD_CFG;
                    end
                end
                ST_RD_CFG: begin
                    cfg_word_r <= rdata;
                    if (need_prev_s) begin
                        rw_addr <= cfg_addr_s - 32'd1;
                        state_r <= ST_RD_PREV;
                    end else begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_RD_PREV: begin
                    prev_word_r <= rdata;
                    state_r     <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (eval_status_s != STAT_OK) begin
                        done_status_r <= eval_status_s;
                        done_valid_r  <= 1'b1;
                        state_r       <= ST_DONE;
                    end else if ((mode_r == MODE_TOR) && (entry_r != 4'd0)) begin
                        wr_en   <= 1'b1;
                        rw_addr <= PMPADDR_BASE + {28'd0, entry_r} - 32'd1;
                        wdata   <= lo_val_s;
                        state_r <= ST_WR_LO;
                    end else if (mode_r == MODE_OFF) begin
                        wr_en   <= 1'b1;
                        rw_addr <= cfg_addr_s;
                        wdata   <= cfg_merged_s;
                        state_r <= ST_WR_CFG;
                    end else begin
                        wr_en   <= 1'b1;
                        rw_addr <= PMPADDR_BASE + {28'd0, entry_r};
                        wdata   <= addr_val_s;
                        state_r <= ST_WR_ADDR;
                    end
                end
                ST_WR_LO: begin
                    wr_en   <= 1'b1;
                    rw_addr <= PMPADDR_BASE + {28'd0, entry_r};
                    wdata   <= addr_val_s;
                    state_r <= ST_WR_ADDR;
                end
                ST_WR_ADDR: begin
                    wr_en   <= 1'b1;
                    rw_addr <= cfg_addr_s;
                    wdata   <= cfg_merged_s;
                    state_r <= ST_WR_CFG;
                end
                ST_WR_CFG: begin
                    done_status_r <= STAT_OK;
                    done_valid_r  <= 1'b1;
                    state_r       <= ST_DONE;
                end
                ST_DONE: begin
                    ready_r       <= 1'b1;
                    csr_priv_mode <= 2'b01;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    ready_r       <= 1'b1;
                    csr_priv_mode <= 2'b01;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_programmer.sv
// Randomized bench for pmp_programmer: a CSR memory answers reads, and a
// request-level model predicts status, latency and the CSR write sequence.
module tb_pmp_programmer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  csr_priv_mode;
    logic [31:0] rw_addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [31:0] rdata;

    logic [31:0] cfg_mem  [4];
    logic [31:0] addr_mem [16];

    int total = 0;
    int bad   = 0;

    int          exp_status;
    int          exp_lat;
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    always #5 clock = ~clock;

    pmp_programmer_if bus ();

    pmp_programmer dut (
        .clock         (clock),
        .reset         (reset),
        .host          (bus),
        .csr_priv_mode (csr_priv_mode),
        .rw_addr       (rw_addr),
        .wdata         (wdata),
        .wr_en         (wr_en),
        .rdata         (rdata)
    );

    always_comb begin
        rdata = 32'd0;
        if (rw_addr >= 32'h3A0 && rw_addr <= 32'h3A3) rdata = cfg_mem[rw_addr[1:0]];
        else if (rw_addr >= 32'h3B0 && rw_addr <= 32'h3BF) rdata = addr_mem[rw_addr[3:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int idx);
        logic [31:0] w;
        w = cfg_mem[idx / 4];
        return 8'((w >> (8 * (idx % 4))) & 32'hFF);
    endfunction

    // Request-level reference: legality rules, write list and cycle count
    task automatic model(input int e, input int m, input logic [31:0] base, input int sz,
                         input logic [2:0] perm, input logic lk);
        longint unsigned b, span, top, v;
        logic [7:0] tbyte, pbyte;
        logic [31:0] w;
        int rdprev;
        exp_wa.delete();
        exp_wd.delete();
        b     = 64'(base);
        span  = 64'd1 << sz;
        top   = b + span;
        rdprev = (m == 1 && e != 0 && e % 4 == 0) ? 1 : 0;
        tbyte = byte_of(e);
        pbyte = (e > 0) ? byte_of(e - 1) : 8'd0;
        if (tbyte[7] || (m == 1 && e > 0 && pbyte[7])) exp_status = 1;
        else if ((perm[1] && !perm[0]) || (m == 2 && (sz != 2 || b % 4 != 0)) ||
                 (m == 3 && (sz < 3 || sz > 32 || b % span != 0))) exp_status = 2;
        else if (m == 1 && (sz < 2 || sz > 32 || top > 64'h1_0000_0000 || (e == 0 && b != 0)))
            exp_status = 3;
        else exp_status = 0;
        if (exp_status == 0) begin
            if (m == 1 && e > 0) begin
                exp_wa.push_back(32'h3B0 + 32'(e - 1));
                exp_wd.push_back(base >> 2);
            end
            if (m != 0) begin
                if (m == 2) v = b / 4;
                else if (m == 3) v = (b / 4) | ((64'd1 << (sz - 3)) - 64'd1);
                else v = top / 4;
                exp_wa.push_back(32'h3B0 + 32'(e));
                exp_wd.push_back(32'(v));
            end
            w = cfg_mem[e / 4];
            w[8 * (e % 4) +: 8] = {lk, 2'b00, 2'(m), perm};
            exp_wa.push_back(32'h3A0 + 32'(e / 4));
            exp_wd.push_back(w);
            exp_lat = 3 + rdprev + exp_wa.size();
        end else begin
            exp_lat = 3 + rdprev;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("ready_before_req", bus.req_ready, 1'b1);
    endtask

    task automatic run_txn(input int e, input int m, input logic [31:0] base, input int sz,
                           input logic [2:0] perm, input logic lk);
        int cyc;
        bit seen;
        logic [31:0] ga[$];
        logic [31:0] gd[$];
        model(e, m, base, sz, perm, lk);
        wait_ready();
        bus.req_entry     = 4'(e);
        bus.req_mode      = 2'(m);
        bus.req_base      = base;
        bus.req_size_log2 = 6'(sz);
        bus.req_perm      = perm;
        bus.req_lock      = lk;
        bus.req_valid     = 1'b1;
        @(posedge clock); #1;
        // keep req_valid high with garbage fields: must be ignored while busy
        bus.req_entry     = 4'($urandom);
        bus.req_mode      = 2'($urandom);
        bus.req_base      = $urandom;
        bus.req_size_log2 = 6'($urandom);
        bus.req_perm      = 3'($urandom);
        bus.req_lock      = 1'($urandom);
        check("busy_ready", bus.req_ready, 1'b0);
        check("busy_priv", csr_priv_mode, 2'b00);
        cyc  = 1;
        seen = 0;
        while (cyc <= 20) begin
            if (wr_en) begin
                ga.push_back(rw_addr);
                gd.push_back(wdata);
            end
            if (bus.done_valid) begin
                seen = 1;
                break;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.req_valid = 1'b0;
        check("done_seen", seen, 1'b1);
        check("latency", cyc, exp_lat);
        check("status", bus.done_status, exp_status);
        check("n_writes", ga.size(), exp_wa.size());
        for (int i = 0; i < ga.size() && i < exp_wa.size(); i++) begin
            check("wr_addr", ga[i], exp_wa[i]);
            check("wr_data", gd[i], exp_wd[i]);
        end
        for (int i = 0; i < ga.size(); i++) begin
            if (ga[i] >= 32'h3A0 && ga[i] <= 32'h3A3) cfg_mem[ga[i][1:0]] = gd[i];
            else if (ga[i] >= 32'h3B0 && ga[i] <= 32'h3BF) addr_mem[ga[i][3:0]] = gd[i];
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) cfg_mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) addr_mem[i] = 32'd0;
    endtask

    task automatic random_mem();
        logic [7:0] bt;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                bt = 8'($urandom) & 8'h7F;
                if ($urandom_range(0, 9) == 0) bt = bt | 8'h80;
                cfg_mem[i][8 * j +: 8] = bt;
            end
        end
        for (int i = 0; i < 16; i++) addr_mem[i] = $urandom;
    endtask

    initial begin
        int sz, m, e;
        logic [31:0] base;
        bit no_activity;
        clear_mem();
        reset             = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_entry     = 4'd0;
        bus.req_mode      = 2'd0;
        bus.req_base      = 32'd0;
        bus.req_size_log2 = 6'd0;
        bus.req_perm      = 3'd0;
        bus.req_lock      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_done_valid", bus.done_valid, 1'b0);
        check("rst_done_status", bus.done_status, 2'd0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_rw_addr", rw_addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_priv", csr_priv_mode, 2'b01);
        reset = 1'b0;
        @(posedge clock); #1;

        cfg_mem[1] = 32'hAABB_CCDD;
        run_txn(5, 3, 32'h8000_0000, 12, 3'b011, 1'b0);
        clear_mem();
        run_txn(4, 1, 32'h0000_1000, 8, 3'b111, 1'b0);
        cfg_mem[0] = 32'h0080_0000;
        run_txn(2, 3, 32'h8000_0000, 12, 3'b011, 1'b0);
        clear_mem();
        run_txn(6, 3, 32'h0000_1800, 12, 3'b011, 1'b0);
        run_txn(6, 2, 32'h0000_0100, 2, 3'b010, 1'b0);
        run_txn(0, 1, 32'h0000_0010, 8, 3'b001, 1'b0);
        run_txn(1, 1, 32'hFFFF_FF00, 9, 3'b001, 1'b0);
        run_txn(3, 0, 32'h0, 0, 3'b000, 1'b0);
        run_txn(0, 1, 32'h0, 32, 3'b101, 1'b0);
        run_txn(9, 3, 32'h0, 32, 3'b001, 1'b0);
        run_txn(7, 2, 32'h0000_1234, 2, 3'b101, 1'b1);
        run_txn(7, 3, 32'h0000_0000, 12, 3'b001, 1'b0);
        run_txn(8, 1, 32'h0000_4000, 12, 3'b001, 1'b0);

        // reset while the pmpaddr write is on the bus
        clear_mem();
        wait_ready();
        bus.req_entry     = 4'd1;
        bus.req_mode      = 2'd3;
        bus.req_base      = 32'h0001_0000;
        bus.req_size_log2 = 6'd12;
        bus.req_perm      = 3'b001;
        bus.req_lock      = 1'b0;
        bus.req_valid     = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_mid_pre_wr_en", wr_en, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_mid_wr_en", wr_en, 1'b0);
        check("rst_mid_ready", bus.req_ready, 1'b1);
        check("rst_mid_done", bus.done_valid, 1'b0);
        check("rst_mid_priv", csr_priv_mode, 2'b01);
        no_activity = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (wr_en || bus.done_valid) no_activity = 0;
        end
        check("rst_mid_quiet", no_activity, 1'b1);

        for (int t = 0; t < 160; t++) begin
            if (t % 8 == 0) random_mem();
            e = $urandom_range(0, 15);
            m = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) sz = $urandom_range(2, 16);
            else sz = $urandom_range(0, 40);
            base = $urandom;
            if ($urandom_range(0, 3) != 0 && sz < 32) base = base & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 3) == 0 && sz >= 32) base = 32'd0;
            if (m == 1 && e == 0 && $urandom_range(0, 1) == 0) base = 32'd0;
            run_txn(e, m, base, sz, 3'($urandom), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
